// File: rtl/game_flow_controller_pkg.sv
// Shared definitions for the frog/car game sequencer: state encoding and field widths.
package game_flow_controller_pkg;

    localparam int unsigned LIVES_W = 2;
    localparam int unsigned LEVEL_W = 4;

    // Encoding is visible on o_State and decoded by the VGA overlays.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } game_state_e;

    // Lives never wrap below zero.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] lives);
        return (lives == '0) ? '0 : lives - LIVES_W'(1);
    endfunction

endpackage

// File: rtl/game_flow_controller_hold.sv
// Hold timer: load starts a hold of HOLD_CYCLES cycles; o_Done is high in its last cycle.
module game_flow_controller_hold #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Load,
    output logic o_Done
);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;

    // Count register; a reset aborts any hold in progress.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

    // Load, count down, and stop after the zero cycle.
    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (i_Load) begin
            count_d  = LOAD_VAL;
            active_d = 1'b1;
        end else if (active_q) begin
            if (count_q == '0) active_d = 1'b0;
            else               count_d  = count_q - CNT_W'(1);
        end
    end

    assign o_Done = active_q && (count_q == '0);

endmodule

// File: rtl/game_flow_controller.sv
// Game-level sequencer: owns lives, level and game state; freezes cars and resets the frog.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter int unsigned FLASH_DIV   = 3_125_000,
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned MAX_LEVEL   = 9
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Start,
    input  logic               i_Collision,
    input  logic               i_Frog_At_Top,
    output logic [2:0]         o_State,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Freeze,
    output logic               o_Reset_Frog,
    output logic               o_Flash
);
    localparam int unsigned FLASH_W = $clog2(FLASH_DIV + 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

    game_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               freeze_q, freeze_d;
    logic               reset_frog_q, reset_frog_d;
    logic               flash_q, flash_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               start_prev_q, coll_prev_q, top_prev_q;
    logic               start_rise, coll_rise, top_rise;
    logic               hold_load, hold_done;

    game_flow_controller_hold #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Load  (hold_load),
        .o_Done  (hold_done)
    );

    assign start_rise = i_Start       && !start_prev_q;
    assign coll_rise  = i_Collision   && !coll_prev_q;
    assign top_rise   = i_Frog_At_Top && !top_prev_q;

    // State, outputs and edge history; history updates every cycle so holds defer nothing.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            level_q      <= '0;
            lives_q      <= LIVES_INIT;
            freeze_q     <= 1'b1;
            reset_frog_q <= 1'b0;
            flash_q      <= 1'b0;
            flash_cnt_q  <= '0;
            start_prev_q <= 1'b0;
            coll_prev_q  <= 1'b0;
            top_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            freeze_q     <= freeze_d;
            reset_frog_q <= reset_frog_d;
            flash_q      <= flash_d;
            flash_cnt_q  <= flash_cnt_d;
            start_prev_q <= i_Start;
            coll_prev_q  <= i_Collision;
            top_prev_q   <= i_Frog_At_Top;
        end
    end

    // Next-state and next-output logic for the game sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        reset_frog_d = 1'b0;
        flash_d      = 1'b0;
        flash_cnt_d  = '0;
        hold_load    = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER, ST_WIN: begin
                if (start_rise) begin
                    state_d      = ST_PLAY;
                    level_d      = '0;
                    lives_d      = LIVES_INIT;
                    reset_frog_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (coll_rise) begin
                    state_d   = ST_HIT;
                    lives_d   = lives_dec(lives_q);
                    hold_load = 1'b1;
                    flash_d   = 1'b1;
                end else if (top_rise) begin
                    if (level_q < LEVEL_MAX) begin
                        state_d   = ST_LEVEL_UP;
                        level_d   = level_q + LEVEL_W'(1);
                        hold_load = 1'b1;
                    end else begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_HIT: begin
                if (hold_done) begin
                    if (lives_q == '0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d      = ST_PLAY;
                        reset_frog_d = 1'b1;
                    end
                end else if (flash_cnt_q == FLASH_LAST) begin
                    flash_d = !flash_q;
                end else begin
                    flash_d     = flash_q;
                    flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                end
            end
            ST_LEVEL_UP: begin
                if (hold_done) begin
                    state_d      = ST_PLAY;
                    reset_frog_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d = (state_d != ST_PLAY);
    end

    assign o_State      = state_q;
    assign o_Level      = level_q;
    assign o_Lives      = lives_q;
    assign o_Freeze     = freeze_q;
    assign o_Reset_Frog = reset_frog_q;
    assign o_Flash      = flash_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed scenario bench for game_flow_controller (HOLD=8, FLASH_DIV=2, LIVES=3, MAX_LEVEL=2).
module tb_game_flow_controller;
    localparam logic [2:0] S_IDLE = 3'd0, S_PLAY = 3'd1, S_HIT = 3'd2,
                           S_LVL  = 3'd3, S_OVER = 3'd4, S_WIN = 3'd5;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, coll = 1'b0, top = 1'b0;
    logic [2:0] st;
    logic [3:0] lvl;
    logic [1:0] lives;
    logic frz, rf, fl;
    int tests_run = 0;
    int tests_failed = 0;

    game_flow_controller #(
        .HOLD_CYCLES(8), .FLASH_DIV(2), .START_LIVES(3), .MAX_LEVEL(2)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Collision(coll),
        .i_Frog_At_Top(top), .o_State(st), .o_Level(lvl), .o_Lives(lives),
        .o_Freeze(frz), .o_Reset_Frog(rf), .o_Flash(fl)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        tests_run++; if (st !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", st, S_IDLE); end
        tests_run++; if (lives !== 2'd3) begin tests_failed++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        tests_run++; if (lvl !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", lvl); end
        tests_run++; if ({frz, rf, fl} !== 3'b100) begin tests_failed++; $display("FAIL reset_flags: got %b expected 100", {frz, rf, fl}); end
        repeat (2) tick();
        rst = 1'b0;
        tick();
        tests_run++; if (st !== S_IDLE) begin tests_failed++; $display("FAIL idle_after_reset: got %0d expected %0d", st, S_IDLE); end
    endtask

    task automatic test_start;
        start = 1'b1;
        tick();
        tests_run++; if (st !== S_PLAY) begin tests_failed++; $display("FAIL start_state: got %0d expected %0d", st, S_PLAY); end
        tests_run++; if ({frz, rf} !== 2'b01) begin tests_failed++; $display("FAIL start_freeze_pulse: got %b expected 01", {frz, rf}); end
        tick();
        tests_run++; if (rf !== 1'b0) begin tests_failed++; $display("FAIL start_pulse_width: got %b expected 0", rf); end
        repeat (3) tick();
        tests_run++; if ({st, rf} !== {S_PLAY, 1'b0}) begin tests_failed++; $display("FAIL start_held: got %b expected %b", {st, rf}, {S_PLAY, 1'b0}); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_hit;
        bit pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        coll = 1'b1;
        tick();
        coll = 1'b0;
        tests_run++; if (lives !== 2'd2) begin tests_failed++; $display("FAIL hit_lives: got %0d expected 2", lives); end
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if ({st, frz, fl} !== {S_HIT, 1'b1, pat[i]}) begin
                tests_failed++;
                $display("FAIL hit_cycle%0d: got st=%0d frz=%b fl=%b expected st=2 frz=1 fl=%b", i, st, frz, fl, pat[i]);
            end
            tick();
        end
        tests_run++; if ({st, frz, rf, fl} !== {S_PLAY, 3'b010}) begin tests_failed++; $display("FAIL hit_exit: got %b expected %b", {st, frz, rf, fl}, {S_PLAY, 3'b010}); end
        tick();
        tests_run++; if (rf !== 1'b0) begin tests_failed++; $display("FAIL hit_exit_pulse: got %b expected 0", rf); end
    endtask

    task automatic test_game_over;
        for (int k = 1; k >= 0; k--) begin
            coll = 1'b1;
            tick();
            coll = 1'b0;
            tests_run++; if (lives !== 2'(k)) begin tests_failed++; $display("FAIL over_lives: got %0d expected %0d", lives, k); end
            repeat (8) tick();
        end
        tests_run++; if ({st, frz, rf} !== {S_OVER, 2'b10}) begin tests_failed++; $display("FAIL over_state: got %b expected %b", {st, frz, rf}, {S_OVER, 2'b10}); end
        coll = 1'b1;
        tick();
        coll = 1'b0;
        tests_run++; if ({st, lives} !== {S_OVER, 2'd0}) begin tests_failed++; $display("FAIL over_ignore_coll: got %b expected %b", {st, lives}, {S_OVER, 2'd0}); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++; if ({st, lives, rf} !== {S_PLAY, 2'd3, 1'b1}) begin tests_failed++; $display("FAIL over_restart: got %b expected %b", {st, lives, rf}, {S_PLAY, 2'd3, 1'b1}); end
        tick();
    endtask

    task automatic test_level_up;
        for (int k = 1; k <= 2; k++) begin
            top = 1'b1;
            tick();
            top = 1'b0;
            tests_run++; if ({st, lvl, frz, fl} !== {S_LVL, 4'(k), 2'b10}) begin tests_failed++; $display("FAIL lvl_enter%0d: got %b expected %b", k, {st, lvl, frz, fl}, {S_LVL, 4'(k), 2'b10}); end
            repeat (7) tick();
            tests_run++; if (st !== S_LVL) begin tests_failed++; $display("FAIL lvl_hold%0d: got %0d expected %0d", k, st, S_LVL); end
            tick();
            tests_run++; if ({st, rf, frz} !== {S_PLAY, 2'b10}) begin tests_failed++; $display("FAIL lvl_exit%0d: got %b expected %b", k, {st, rf, frz}, {S_PLAY, 2'b10}); end
        end
        top = 1'b1;
        tick();
        top = 1'b0;
        tests_run++; if ({st, lvl, frz} !== {S_WIN, 4'd2, 1'b1}) begin tests_failed++; $display("FAIL win: got %b expected %b", {st, lvl, frz}, {S_WIN, 4'd2, 1'b1}); end
        tick();
    endtask

    task automatic test_simultaneous;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++; if ({st, lvl, lives} !== {S_PLAY, 4'd0, 2'd3}) begin tests_failed++; $display("FAIL sim_restart: got %b expected %b", {st, lvl, lives}, {S_PLAY, 4'd0, 2'd3}); end
        tick();
        coll = 1'b1; top = 1'b1;
        tick();
        coll = 1'b0; top = 1'b0;
        tests_run++; if ({st, lvl, lives} !== {S_HIT, 4'd0, 2'd2}) begin tests_failed++; $display("FAIL sim_priority: got %b expected %b", {st, lvl, lives}, {S_HIT, 4'd0, 2'd2}); end
        repeat (2) tick();
        coll = 1'b1;
        tick();
        tests_run++; if ({st, lives} !== {S_HIT, 2'd2}) begin tests_failed++; $display("FAIL sim_coll_in_hold: got %b expected %b", {st, lives}, {S_HIT, 2'd2}); end
        repeat (4) tick();
        tests_run++; if (st !== S_HIT) begin tests_failed++; $display("FAIL sim_hold_len: got %0d expected %0d", st, S_HIT); end
        tick();
        tests_run++; if ({st, lives} !== {S_PLAY, 2'd2}) begin tests_failed++; $display("FAIL sim_exit: got %b expected %b", {st, lives}, {S_PLAY, 2'd2}); end
        tick();
        tests_run++; if ({st, lives} !== {S_PLAY, 2'd2}) begin tests_failed++; $display("FAIL sim_no_deferred: got %b expected %b", {st, lives}, {S_PLAY, 2'd2}); end
        coll = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hit;
        top = 1'b1;
        tick();
        top = 1'b0;
        repeat (8) tick();
        tests_run++; if ({st, lvl} !== {S_PLAY, 4'd1}) begin tests_failed++; $display("FAIL mid_setup: got %b expected %b", {st, lvl}, {S_PLAY, 4'd1}); end
        coll = 1'b1;
        tick();
        coll = 1'b0;
        repeat (3) tick();
        tests_run++; if ({st, lives, fl} !== {S_HIT, 2'd1, 1'b0}) begin tests_failed++; $display("FAIL mid_in_hit: got %b expected %b", {st, lives, fl}, {S_HIT, 2'd1, 1'b0}); end
        tick();
        tests_run++; if (fl !== 1'b1) begin tests_failed++; $display("FAIL mid_flash_on: got %b expected 1", fl); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if ({st, lives, lvl} !== {S_IDLE, 2'd3, 4'd0}) begin tests_failed++; $display("FAIL mid_reset_vals: got %b expected %b", {st, lives, lvl}, {S_IDLE, 2'd3, 4'd0}); end
        tests_run++; if ({frz, rf, fl} !== 3'b100) begin tests_failed++; $display("FAIL mid_reset_flags: got %b expected 100", {frz, rf, fl}); end
        tick();
        rst = 1'b0;
        repeat (10) tick();
        tests_run++; if ({st, frz, rf} !== {S_IDLE, 2'b10}) begin tests_failed++; $display("FAIL mid_hold_aborted: got %b expected %b", {st, frz, rf}, {S_IDLE, 2'b10}); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_game_over();
        test_level_up();
        test_simultaneous();
        test_reset_mid_hit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
